// File: rtl/corefifo_rd_ctrl.sv
// corefifo_rd_ctrl: read-side pointer, flag and RAM-read sequencing for the dual-clock FIFO.
// Level is computed against the synchronized (lagging) write pointer, so flags err on the empty side.
module corefifo_rd_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int AEVAL     = 2
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 srstn,
    input  logic [ADDRWIDTH:0]   wptr_gray_sync,
    input  logic                 re,
    output logic                 ren,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic                 rd_valid,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 underflow,
    output logic                 ptr_err
);
    localparam logic [ADDRWIDTH:0] DEPTH = (ADDRWIDTH+1)'(1 << ADDRWIDTH);
    localparam logic [ADDRWIDTH:0] AE    = (ADDRWIDTH+1)'(AEVAL);

    logic [ADDRWIDTH:0] rptr_bin, wbin, rptr_next, lvl_next;

    always_comb begin
        wbin[ADDRWIDTH] = wptr_gray_sync[ADDRWIDTH];
        for (int i = ADDRWIDTH - 1; i >= 0; i--)
            wbin[i] = wbin[i+1] ^ wptr_gray_sync[i];
    end

    assign ren       = re & ~empty;
    assign raddr     = rptr_bin[ADDRWIDTH-1:0];
    assign rptr_next = rptr_bin + (ADDRWIDTH+1)'(ren);
    assign lvl_next  = wbin - rptr_next;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn || !srstn) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            rdcnt     <= '0;
            empty     <= 1'b1;
            aempty    <= 1'b1;
            rd_valid  <= 1'b0;
            underflow <= 1'b0;
            ptr_err   <= 1'b0;
        end else begin
            rptr_bin  <= rptr_next;
            rptr_gray <= rptr_next ^ (rptr_next >> 1);
            rdcnt     <= lvl_next;
            empty     <= (lvl_next == '0);
            aempty    <= (lvl_next <= AE);
            rd_valid  <= ren;
            underflow <= re & empty;
            ptr_err   <= ptr_err | (lvl_next > DEPTH);
        end
    end
endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// tb_corefifo_rd_ctrl: scoreboard bench; a count-based reference model queues the expected
// outputs per cycle and an independent monitor pops and compares them on the falling edge.
module tb_corefifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       srstn = 1'b1;
    logic [3:0] wptr_gray_sync = '0;
    logic       re = 1'b0;
    logic       ren, rd_valid, empty, aempty, underflow, ptr_err;
    logic [2:0] raddr;
    logic [3:0] rptr_gray, rdcnt;

    corefifo_rd_ctrl #(.ADDRWIDTH(3), .AEVAL(2)) dut (
        .clk(clk), .arstn(arstn), .srstn(srstn), .wptr_gray_sync(wptr_gray_sync), .re(re),
        .ren(ren), .raddr(raddr), .rptr_gray(rptr_gray), .rd_valid(rd_valid), .empty(empty),
        .aempty(aempty), .rdcnt(rdcnt), .underflow(underflow), .ptr_err(ptr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rg, cnt;
        logic       e, ae, rv, uf, pe, ren;
        logic [2:0] ra;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;

    // Reference model: reads consumed (mod 16), writes seen (mod 16), registered flags.
    int mr = 0, mw = 0, mc = 0;
    bit me = 1, mae = 1, mrv = 0, mu = 0, mpe = 0;

    function automatic void chk(string n, logic [7:0] a, logic [7:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endfunction

    task automatic model_reset();
        mr = 0; mc = 0; me = 1; mae = 1; mrv = 0; mu = 0; mpe = 0;
    endtask

    task automatic push_exp(bit rd);
        exp_t x;
        x.rg = 4'(mr ^ (mr >> 1)); x.cnt = 4'(mc);
        x.e = me; x.ae = mae; x.rv = mrv; x.uf = mu; x.pe = mpe;
        x.ren = rd; x.ra = 3'(mr & 7);
        q.push_back(x);
    endtask

    task automatic step(bit r, int w, bit sr = 1'b1);
        bit rd;
        int lvl;
        re = r; mw = w & 15; wptr_gray_sync = 4'(mw ^ (mw >> 1)); srstn = sr;
        rd = r && !me;
        push_exp(rd);
        if (!sr) model_reset();
        else begin
            mu  = r && me;
            mr  = (mr + int'(rd)) & 15;
            lvl = (mw - mr) & 15;
            mc  = lvl; me = (lvl == 0); mae = (lvl <= 2); mrv = rd; mpe = mpe || (lvl > 8);
        end
        @(posedge clk); #1;
        srstn = 1'b1;
    endtask

    task automatic do_areset();
        arstn = 1'b0; re = 1'b1;
        model_reset();
        push_exp(1'b0);
        @(posedge clk); #1;
        arstn = 1'b1; re = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("ren", 8'(ren), 8'(x.ren));
            chk("raddr", 8'(raddr), 8'(x.ra));
            chk("rptr_gray", 8'(rptr_gray), 8'(x.rg));
            chk("rdcnt", 8'(rdcnt), 8'(x.cnt));
            chk("empty", 8'(empty), 8'(x.e));
            chk("aempty", 8'(aempty), 8'(x.ae));
            chk("rd_valid", 8'(rd_valid), 8'(x.rv));
            chk("underflow", 8'(underflow), 8'(x.uf));
            chk("ptr_err", 8'(ptr_err), 8'(x.pe));
        end
    end

    initial begin
        int nw, lv;
        @(posedge clk); #1;
        do_areset();
        step(0, 5);
        for (int i = 0; i < 5; i++) step(1, 5);
        step(1, 5); step(1, 5); step(0, 5);
        step(0, 8);
        for (int i = 0; i < 8; i++) step(1, 8);
        step(0, 12);
        for (int i = 0; i < 4; i++) step(1, 12);
        step(0, 4);
        for (int i = 0; i < 8; i++) step(1, 4);
        step(0, 4);
        step(0, 5); step(1, 6); step(0, 6);
        step(0, 9); step(1, 9); step(1, 9, 1'b0); step(0, 9);
        step(0, 0); step(0, 1);
        do_areset();
        step(0, 0);
        step(0, 2); step(1, 4); step(1, 4);
        do_areset();
        step(0, 0);
        for (int i = 0; i < 400; i++) begin
            lv = (mw - mr) & 15;
            nw = (lv < 8 && $urandom_range(1) == 1) ? mw + 1 : mw;
            step(bit'($urandom_range(1)), nw, bit'($urandom_range(39) != 0));
        end
        re = 1'b0;
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) chk("scoreboard_drain", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
